// File: rtl/send_response.sv
// Response transmitter: buffers completed DDR4 transactions in a small FIFO and presents them to
// the cache one at a time over a four-phase valid/ack handshake.
module send_response #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rsp_valid,
    input  logic              rsp_rw,
    input  logic [2:0]        rsp_tag,
    input  logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_ready,
    output logic              valid_resp,
    output logic              rw_resp,
    output logic [2:0]        tag_resp,
    output logic [DWIDTH-1:0] data_resp,
    input  logic              ack_resp,
    output logic              overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {StIdle, StPresent, StWaitDrop} state_e;

    state_e state_q, state_d;

    logic [DWIDTH-1:0] data_mem [DEPTH];
    logic              rw_mem   [DEPTH];
    logic [2:0]        tag_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          rw_q;
    logic [2:0]    tag_q;
    logic [DWIDTH-1:0] data_q;

    logic full, push_en, pop_en;

    // Full-check uses the pre-edge count only: a pop on the same edge does not free a slot.
    assign full      = (count_q == CW'(DEPTH));
    assign push_en   = rsp_valid && !full;
    assign pop_en    = (state_q == StIdle) && (count_q != '0);
    assign rsp_ready = !full;

    always_comb begin
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            data_mem[wr_ptr_q] <= rsp_data;
            rw_mem[wr_ptr_q]   <= rsp_rw;
            tag_mem[wr_ptr_q]  <= rsp_tag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rw_q       <= 1'b0;
            tag_q      <= '0;
            data_q     <= '0;
        end else begin
            count_q <= count_d;
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rsp_valid && full) begin
                overflow_q <= 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rw_q     <= rw_mem[rd_ptr_q];
                tag_q    <= tag_mem[rd_ptr_q];
                // Write completions carry no payload.
                data_q   <= rw_mem[rd_ptr_q] ? data_mem[rd_ptr_q] : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (count_q != '0) state_d = StPresent;
            StPresent:  if (ack_resp)      state_d = StWaitDrop;
            StWaitDrop: if (!ack_resp)     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_resp = (state_q == StPresent);
        rw_resp    = rw_q;
        tag_resp   = tag_q;
        data_resp  = data_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_send_response.sv
// Randomised bench for send_response, checked against a queue-based handshake model.
module tb_send_response;

    localparam int DW = 64;
    localparam int DP = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rsp_valid = 1'b0;
    logic          rsp_rw = 1'b0;
    logic [2:0]    rsp_tag = '0;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_ready;
    logic          valid_resp;
    logic          rw_resp;
    logic [2:0]    tag_resp;
    logic [DW-1:0] data_resp;
    logic          ack_resp = 1'b0;
    logic          overflow;

    send_response #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rsp_valid  (rsp_valid),
        .rsp_rw     (rsp_rw),
        .rsp_tag    (rsp_tag),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .valid_resp (valid_resp),
        .rw_resp    (rw_resp),
        .tag_resp   (tag_resp),
        .data_resp  (data_resp),
        .ack_resp   (ack_resp),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          rw;
        logic [2:0]    tag;
        logic [DW-1:0] data;
    } rsp_t;

    localparam logic [70:0] RESET_VEC = {1'b0, 1'b0, 3'b0, 64'b0, 1'b1, 1'b0};

    // Model: pending entries, the entry being shown, and whether the cache still owes an ack drop.
    rsp_t mq[$];
    rsp_t m_cur;
    bit   m_show, m_drain, m_ovf;
    int   acc_tags[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [70:0] dut_vec();
        return {valid_resp, rw_resp, tag_resp, data_resp, rsp_ready, overflow};
    endfunction

    function automatic logic [70:0] mdl_vec();
        return {m_show, m_cur.rw, m_cur.tag, m_cur.data, (mq.size() < DP), m_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        acc_tags.delete();
        m_cur   = '0;
        m_show  = 1'b0;
        m_drain = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        rsp_valid = 1'b0;
        ack_resp  = 1'b0;
        #3;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic tick(input logic v, input logic rw, input logic [2:0] tag,
                        input logic [DW-1:0] data, input logic a);
        int   n;
        rsp_t e;
        rsp_valid = v;
        rsp_rw    = rw;
        rsp_tag   = tag;
        rsp_data  = data;
        ack_resp  = a;
        @(posedge clock);
        n = mq.size();
        if (!m_show && !m_drain && n > 0) begin
            m_cur  = mq.pop_front();
            m_show = 1'b1;
        end else if (m_show && a) begin
            m_show  = 1'b0;
            m_drain = 1'b1;
        end else if (m_drain && !a) begin
            m_drain = 1'b0;
        end
        if (v) begin
            if (n < DP) begin
                e.rw   = rw;
                e.tag  = tag;
                e.data = rw ? data : '0;
                mq.push_back(e);
                acc_tags.push_back(int'(tag));
            end else begin
                m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (dut_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec(), RESET_VEC);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        tick(1'b1, 1'b1, 3'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        total++;
        if (valid_resp !== 1'b0) begin
            bad++;
            $display("FAIL read_latency_early got=%b exp=0", valid_resp);
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if ({valid_resp, rw_resp, tag_resp, data_resp} !==
            {1'b1, 1'b1, 3'd5, 64'hDEAD_BEEF_0000_0001}) begin
            bad++;
            $display("FAIL read_present got=%b/%b/%0d/%h exp=1/1/5/deadbeef00000001",
                     valid_resp, rw_resp, tag_resp, data_resp);
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b1);
        total++;
        if (valid_resp !== 1'b0) begin
            bad++;
            $display("FAIL read_ack_drop got=%b exp=0", valid_resp);
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL read_return_idle got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_write_completion();
        apply_reset();
        tick(1'b1, 1'b0, 3'd2, 64'hFFFF, 1'b0);
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if ({valid_resp, rw_resp, tag_resp, data_resp} !== {1'b1, 1'b0, 3'd2, 64'h0}) begin
            bad++;
            $display("FAIL write_present got=%b/%b/%0d/%h exp=1/0/2/0",
                     valid_resp, rw_resp, tag_resp, data_resp);
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL write_done got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_overflow();
        int   got[$];
        logic prev;
        int   cyc;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 3'(i), {$urandom, $urandom}, 1'b0);
        end
        total++;
        if (rsp_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got=%b exp=0", rsp_ready);
        end
        tick(1'b1, 1'b1, 3'd6, {$urandom, $urandom}, 1'b0);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set got=%b exp=1", overflow);
        end
        prev = 1'b0;
        cyc  = 0;
        while (got.size() < 5 && cyc < 60) begin
            if (valid_resp && !prev) got.push_back(int'(tag_resp));
            prev = valid_resp;
            tick(1'b0, 1'b0, 3'd0, '0, valid_resp);
            cyc++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL drain_cycle%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL drain_count got=%0d exp=5", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] != i) begin
                bad++;
                $display("FAIL drain_order idx=%0d got=%0d exp=%0d", i, got[i], i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
            total++;
            if ({valid_resp, overflow} !== 2'b01) begin
                bad++;
                $display("FAIL no_stale_tag6 valid=%b ovf=%b exp valid=0 ovf=1",
                         valid_resp, overflow);
            end
        end
    endtask

    task automatic test_random_traffic();
        int   got[$];
        logic prev;
        int   cyc;
        logic v;
        apply_reset();
        prev = 1'b0;
        cyc  = 0;
        while (got.size() < 10 && cyc < 3000) begin
            if (valid_resp && !prev) got.push_back(int'(tag_resp));
            prev = valid_resp;
            v = (acc_tags.size() < 10) && ($urandom_range(0, 1) == 1);
            tick(v, 1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cyc++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL traffic_cycle%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (got.size() != 10 || acc_tags.size() != 10) begin
            bad++;
            $display("FAIL traffic_count got=%0d exp=%0d", got.size(), acc_tags.size());
        end
        for (int i = 0; i < got.size() && i < acc_tags.size(); i++) begin
            total++;
            if (got[i] != acc_tags[i]) begin
                bad++;
                $display("FAIL traffic_order idx=%0d got=%0d exp=%0d", i, got[i], acc_tags[i]);
            end
        end
    endtask

    task automatic test_ack_hold();
        apply_reset();
        tick(1'b1, 1'b1, 3'd1, 64'h1111, 1'b0);
        tick(1'b1, 1'b1, 3'd7, 64'h7777, 1'b0);
        tick(1'b0, 1'b0, 3'd0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 3'd0, '0, 1'b1);
            total++;
            if (valid_resp !== 1'b0 || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL ack_hold_stall%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if (valid_resp !== 1'b0) begin
            bad++;
            $display("FAIL ack_hold_idle got=%b exp=0", valid_resp);
        end
        tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
        total++;
        if ({valid_resp, tag_resp, data_resp} !== {1'b1, 3'd7, 64'h7777}) begin
            bad++;
            $display("FAIL ack_hold_second got=%b/%0d/%h exp=1/7/7777",
                     valid_resp, tag_resp, data_resp);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 3'(i + 2), {$urandom, $urandom}, 1'b0);
        end
        total++;
        if (valid_resp !== 1'b1 || mq.size() != 3) begin
            bad++;
            $display("FAIL mid_setup valid=%b exp=1", valid_resp);
        end
        rsp_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec() !== RESET_VEC) begin
            bad++;
            $display("FAIL mid_async_reset got=%h exp=%h", dut_vec(), RESET_VEC);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 3'd0, '0, 1'b0);
            total++;
            if (valid_resp !== 1'b0 || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL mid_no_stale%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_completion();
        test_overflow();
        test_random_traffic();
        test_ack_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
